muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer in the EX stage of the 5-stage pipeline.
- Accepts one M-extension operation, holds the pipeline with a stall while it iterates, then presents a one-cycle result.
- Owns the shared add/subtract/shift datapath for all eight M ops.
- Sits beside the ALU; the result is muxed onto the EX result bus by the existing forwarding path.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/muldiv_seq_if.sv | 14 +
 rtl/muldiv_core.sv | 20 ++
 rtl/muldiv_seq.sv | 123 ++++++++++++
 tb/tb_muldiv_seq.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32M encodings and the multiply/divide sequencer state type.
package riscv_pkg;
  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;
  localparam logic [2:0] DIV_F3    = 3'b100;
  localparam logic [2:0] DIVU_F3   = 3'b101;
  localparam logic [2:0] REM_F3    = 3'b110;
  localparam logic [2:0] REMU_F3   = 3'b111;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: EX-stage handshake between the pipeline (master) and the M-op sequencer (slave).
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;
  modport master (output start, funct3, rs1_val, rs2_val, flush, input stall, busy, result_valid, result);
  modport slave (input start, funct3, rs1_val, rs2_val, flush, output stall, busy, result_valid, result);
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: one radix-2 step, shift-add for multiply or restoring shift-subtract for divide.
module muldiv_core #(parameter int XLEN = 32) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opd,
  output logic [2*XLEN-1:0] acc_next
);
  logic [XLEN:0]   sum;
  logic [XLEN:0]   top;
  logic [XLEN-1:0] diff;
  logic            ge;
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    top = acc[2*XLEN-1:XLEN-1];
    ge = top >= {1'b0, opd};
    // when the subtract succeeds the difference always fits in XLEN bits
    diff = top[XLEN-1:0] - opd;
    acc_next = is_div ? {ge ? diff : top[XLEN-1:0], acc[XLEN-2:0], ge} : {sum, acc[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer with pipeline stall.
// Define MULDIV_FASTMUL_EN for single-cycle combinational multiplies.
module muldiv_seq
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   opd;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   fix_res;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   res_q;
  logic              neg_q;
  logic              neg_r;
  logic              sign_a;
  logic              sign_b;
  logic              sa;
  logic              sb;
  logic              div_zero;
  logic              ovf;
  logic              special;

  muldiv_core #(.XLEN(XLEN)) u_core (
    .is_div  (f3[2]),
    .acc     (acc),
    .opd     (opd),
    .acc_next(acc_next)
  );

  always_comb begin
    sign_a = bus.funct3 != MULHU_F3 && bus.funct3 != DIVU_F3 && bus.funct3 != REMU_F3;
    sign_b = sign_a && bus.funct3 != MULHSU_F3;
    sa = sign_a & bus.rs1_val[XLEN-1];
    sb = sign_b & bus.rs2_val[XLEN-1];
    abs_a = sa ? -bus.rs1_val : bus.rs1_val;
    abs_b = sb ? -bus.rs2_val : bus.rs2_val;
    div_zero = bus.funct3[2] && bus.rs2_val == '0;
    ovf = bus.funct3[2] && sign_b && bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2_val == '1;
    special = div_zero | ovf;
    // overflow quotient equals the dividend, so rs1_val serves both bypass cases
    special_res = div_zero ? (bus.funct3[1] ? bus.rs1_val : '1) : (bus.funct3[1] ? '0 : bus.rs1_val);
    prod_fix = neg_q ? -acc_next : acc_next;
    q_fix = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    r_fix = neg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    fix_res = f3[2] ? (f3[1] ? r_fix : q_fix) :
              (f3[1:0] == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
  end

`ifdef MULDIV_FASTMUL_EN
  logic [2*XLEN-1:0] fast_p;
  logic [XLEN-1:0]   fast_res;
  assign fast_p = {{XLEN{sa}}, bus.rs1_val} * {{XLEN{sb}}, bus.rs2_val};
  assign fast_res = bus.funct3[1:0] == 2'b00 ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      acc <= '0;
      opd <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_q <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          f3 <= bus.funct3;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          if (special) begin
            res_q <= special_res;
            state <= DONE;
          end
`ifdef MULDIV_FASTMUL_EN
          else if (!bus.funct3[2]) begin
            res_q <= fast_res;
            state <= DONE;
          end
`endif
          else begin
            acc <= {{XLEN{1'b0}}, abs_a};
            opd <= abs_b;
            cnt <= CW'(XLEN - 1);
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            res_q <= fix_res;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall = (state == IDLE && bus.start && !bus.flush) || state == CALC;
  assign bus.busy = state != IDLE;
  assign bus.result_valid = state == DONE && !bus.flush;
  assign bus.result = res_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table vectors, corner sequences and random ops checked against an arithmetic model.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_tot = 0;

  muldiv_seq_if #(.XLEN(32)) mif ();
  muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(mif));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic sgn_a, sgn_b;
    longint va, vb, p;
    sgn_a = !(f == 3'd3 || f == 3'd5 || f == 3'd7);
    sgn_b = sgn_a && f != 3'd2;
    va = sgn_a ? longint'($signed(a)) : longint'(a);
    vb = sgn_b ? longint'($signed(b)) : longint'(b);
    if (!f[2]) begin
      p = va * vb;
      return f[1:0] == 2'b00 ? p[31:0] : p[63:32];
    end
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (sgn_b && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
    return f[1] ? 32'(va % vb) : 32'(va / vb);
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FASTMUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // cycle 0 is the acceptance cycle; stray starts and operand changes are injected while busy
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit stall_ok);
    @(posedge clk); #1;
    mif.start = 1'b1; mif.funct3 = f; mif.rs1_val = a; mif.rs2_val = b;
    lat = -1; stall_ok = 1'b1; res = 'x;
    for (int c = 0; c < 100 && lat < 0; c++) begin
      @(negedge clk);
      if (mif.result_valid) begin
        lat = c; res = mif.result; stall_ok &= !mif.stall;
      end else stall_ok &= mif.stall;
      @(posedge clk); #1;
      mif.start = lat < 0 ? 1'($urandom_range(0, 1)) : 1'b0;
      mif.funct3 = 3'($urandom); mif.rs1_val = $urandom; mif.rs2_val = $urandom;
    end
  endtask

  task automatic do_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int lat;
    bit sok;
    run_op(f, a, b, res, lat, sok);
    chk({tag, "_res"}, 64'(res), 64'(exp));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(f, a, b)));
    chk({tag, "_stall"}, 64'(sok), 64'd1);
  endtask

  initial begin
    logic [2:0] f;
    logic [31:0] a, b;
    mif.start = 0; mif.funct3 = 0; mif.rs1_val = 0; mif.rs2_val = 0; mif.flush = 0;
    vt[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vt[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    vt[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    vt[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    vt[6]  = '{3'd5, 32'd100, 32'd7, 32'd14};
    vt[7]  = '{3'd7, 32'd100, 32'd7, 32'd2};
    vt[8]  = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF};
    vt[9]  = '{3'd6, 32'd5, 32'd0, 32'd5};
    vt[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vt[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    vt[12] = '{3'd0, 32'd1234, 32'd5678, 32'h006A_E9BC};
    vt[13] = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF};
    vt[14] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    vt[15] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(mif.busy), 0);
    chk("rst_valid", 64'(mif.result_valid), 0);
    chk("rst_result", 64'(mif.result), 0);
    chk("rst_stall", 64'(mif.stall), 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) do_check($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b, vt[i].exp);

    // flush and start together: nothing is accepted
    @(posedge clk); #1;
    mif.start = 1; mif.flush = 1; mif.funct3 = 3'd4; mif.rs1_val = 5; mif.rs2_val = 0;
    @(negedge clk);
    chk("fs_stall", 64'(mif.stall), 0);
    @(posedge clk); #1 mif.start = 0; mif.flush = 0;
    @(negedge clk);
    chk("fs_busy", 64'(mif.busy), 0);
    chk("fs_valid", 64'(mif.result_valid), 0);

    // flush at CALC cycle 10, then a fresh op two cycles later
    @(posedge clk); #1;
    mif.start = 1; mif.funct3 = 3'd3; mif.rs1_val = $urandom; mif.rs2_val = $urandom;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1 mif.start = 0;
    end
    mif.flush = 1;
    @(negedge clk);
    chk("fl_busy_before", 64'(mif.busy), 1);
    @(posedge clk); #1 mif.flush = 0;
    @(negedge clk);
    chk("fl_busy", 64'(mif.busy), 0);
    chk("fl_stall", 64'(mif.stall), 0);
    chk("fl_valid", 64'(mif.result_valid), 0);
    do_check("after_flush", 3'd5, 32'd100, 32'd7, 32'd14);

    // asynchronous reset at CALC cycle 5
    @(posedge clk); #1;
    mif.start = 1; mif.funct3 = 3'd0; mif.rs1_val = 32'd7; mif.rs2_val = 32'd9;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 mif.start = 0;
    end
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", 64'(mif.busy), 0);
    chk("mrst_stall", 64'(mif.stall), 0);
    chk("mrst_valid", 64'(mif.result_valid), 0);
    chk("mrst_result", 64'(mif.result), 0);
    @(posedge clk); #1 rst = 1'b0;
    do_check("after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom);
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = 0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      do_check($sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b), f, a, b, model(f, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
